// File: rtl/cnt_down_timer_if.sv
// cnt_down_timer control/status bundle.
// Master drives setup and commands; slave returns the timer state.
interface cnt_down_timer_if;
  logic [31:0] num;
  logic        load;
  logic [5:0]  load_min;
  logic [5:0]  load_sec;
  logic        start;
  logic        pause;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        running;
  logic        done;

  modport master (
    output num, load, load_min, load_sec, start, pause,
    input  min, sec, running, done
  );

  modport slave (
    input  num, load, load_min, load_sec, start, pause,
    output min, sec, running, done
  );
endinterface

// File: rtl/cnt_down_timer.sv
// mm:ss countdown timer, tick derived from a clk-domain enable divider.
// Optional macro CDT_AUTO_RELOAD_EN: periodic reload on expiry.
module cnt_down_timer #(
  parameter int unsigned MIN_MAX = 59
) (
  input logic             clk,
  input logic             rst,
  cnt_down_timer_if.slave tmr
);

  localparam logic [5:0] MMAX = 6'(MIN_MAX);
  localparam logic [5:0] SMAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  rl_min_q, rl_min_d;
  logic [5:0]  rl_sec_q, rl_sec_d;

  logic [31:0] eff_last;
  logic        tick;
  logic [5:0]  ld_min, ld_sec;
  logic [5:0]  dec_min, dec_sec;
  logic        dec_zero;
  logic        nonzero;

  // divider terminal count, saturated load values and decremented time
  always_comb begin
    eff_last = (tmr.num <= 32'd1) ? 32'd0 : tmr.num - 32'd1;
    tick     = (state_q == RUN) && (cnt_q >= eff_last);
    ld_min   = (tmr.load_min > MMAX) ? MMAX : tmr.load_min;
    ld_sec   = (tmr.load_sec > SMAX) ? SMAX : tmr.load_sec;
    nonzero  = (min_q != 6'd0) || (sec_q != 6'd0);
    if (sec_q != 6'd0) begin
      dec_sec = sec_q - 6'd1;
      dec_min = min_q;
    end else begin
      dec_sec = SMAX;
      dec_min = min_q - 6'd1;
    end
    dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);
  end

  // next-state: load > start > pause, then tick processing in RUN
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    running_d = running_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    rl_min_d  = rl_min_q;
    rl_sec_d  = rl_sec_q;
    if (tmr.load) begin
      min_d     = ld_min;
      sec_d     = ld_sec;
      rl_min_d  = ld_min;
      rl_sec_d  = ld_sec;
      state_d   = IDLE;
      running_d = 1'b0;
      cnt_d     = 32'd0;
    end else if (tmr.start && state_q == IDLE && nonzero) begin
      state_d   = RUN;
      running_d = 1'b1;
      cnt_d     = 32'd0;
    end else if (tmr.start && state_q == PAUSED) begin
      state_d   = RUN;
      running_d = 1'b1;
    end else if (tmr.pause && state_q == RUN) begin
      state_d   = PAUSED;
      running_d = 1'b0;
    end else if (state_q == RUN) begin
      if (tick) begin
        cnt_d = 32'd0;
        min_d = dec_min;
        sec_d = dec_sec;
        if (dec_zero) begin
          done_d = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
          if ((rl_min_q != 6'd0) || (rl_sec_q != 6'd0)) begin
            min_d = rl_min_q;
            sec_d = rl_sec_q;
          end else begin
            state_d   = IDLE;
            running_d = 1'b0;
          end
`else
          state_d   = IDLE;
          running_d = 1'b0;
`endif
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 32'd0;
      rl_min_q  <= 6'd0;
      rl_sec_q  <= 6'd0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      rl_min_q  <= rl_min_d;
      rl_sec_q  <= rl_sec_d;
    end
  end

  assign tmr.min     = min_q;
  assign tmr.sec     = sec_q;
  assign tmr.running = running_q;
  assign tmr.done    = done_q;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Self-checking bench for cnt_down_timer.
// Expected snapshots are queued at stimulus time and popped at check points.
module tb_cnt_down_timer;

`ifdef CDT_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnt_down_timer_if bus ();

  cnt_down_timer #(.MIN_MAX(59)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [5:0] m;
    logic [5:0] s;
    logic       r;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input string tag, input int m, input int s,
                      input bit r, input bit d);
    exp_t e;
    e.tag = tag;
    e.m   = 6'(m);
    e.s   = 6'(s);
    e.r   = r;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".min"}, 32'(bus.min), 32'(e.m));
      check({e.tag, ".sec"}, 32'(bus.sec), 32'(e.s));
      check({e.tag, ".run"}, 32'(bus.running), 32'(e.r));
      check({e.tag, ".done"}, 32'(bus.done), 32'(e.d));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_load(input int m, input int s);
    bus.load_min = 6'(m);
    bus.load_sec = 6'(s);
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  int d0;

  initial begin
    bus.num = 32'd4;
    bus.load = 1'b0;
    bus.load_min = 6'd0;
    bus.load_sec = 6'd0;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    // reset state
    run(2);
    push("rst", 0, 0, 0, 0);
    pop_chk();
    rst = 1'b0;
    cyc();

    // 0:03, num=4
    bus.num = 32'd4;
    push("t1_load", 0, 3, 0, 0);
    do_load(0, 3);
    pop_chk();
    push("t1_start", 0, 3, 1, 0);
    do_start();
    pop_chk();
    d0 = done_cnt;
    for (int v = 2; v >= 0; v--) begin
      run(3);
      push("t1_hold", 0, v + 1, 1, 0);
      pop_chk();
      run(1);
      if (v == 0) push("t1_exp", 0, AR ? 3 : 0, AR, 1);
      else push("t1_dec", 0, v, 1, 0);
      pop_chk();
    end
    run(1);
    push("t1_post", 0, AR ? 3 : 0, AR, 0);
    pop_chk();
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 1:00, num=2
    bus.num = 32'd2;
    push("t2_load", 1, 0, 0, 0);
    do_load(1, 0);
    pop_chk();
    do_start();
    run(2);
    push("t2_first", 0, 59, 1, 0);
    pop_chk();
    run(117);
    push("t2_last", 0, 1, 1, 0);
    pop_chk();
    run(1);
    push("t2_exp", AR ? 1 : 0, 0, AR, 1);
    pop_chk();

    // 0:05, num=10, pause/resume
    bus.num = 32'd10;
    push("t3_load", 0, 5, 0, 0);
    do_load(0, 5);
    pop_chk();
    do_start();
    run(5);
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    push("t3_paused", 0, 5, 0, 0);
    pop_chk();
    run(20);
    push("t3_held", 0, 5, 0, 0);
    pop_chk();
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    push("t3_pause_idle", 0, 5, 0, 0);
    pop_chk();
    push("t3_resume", 0, 5, 1, 0);
    do_start();
    pop_chk();
    run(4);
    push("t3_pre", 0, 5, 1, 0);
    pop_chk();
    run(1);
    push("t3_dec", 0, 4, 1, 0);
    pop_chk();

    // saturation and zero start
    bus.num = 32'd1;
    push("t4_sat", 59, 59, 0, 0);
    do_load(63, 63);
    pop_chk();
    push("t4_zero", 0, 0, 0, 0);
    do_load(0, 0);
    pop_chk();
    d0 = done_cnt;
    do_start();
    run(5);
    push("t4_idle", 0, 0, 0, 0);
    pop_chk();
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // load on expiring tick
    bus.num = 32'd3;
    do_load(0, 1);
    do_start();
    run(2);
    d0 = done_cnt;
    bus.load_min = 6'd0;
    bus.load_sec = 6'd7;
    bus.load = 1'b1;
    push("t5_ldwin", 0, 7, 0, 0);
    cyc();
    bus.load = 1'b0;
    pop_chk();
    run(4);
    push("t5_idle", 0, 7, 0, 0);
    pop_chk();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // async reset mid-RUN
    do_start();
    run(4);
    push("t5_run", 0, 6, 1, 0);
    pop_chk();
    rst = 1'b1;
    #1;
    push("t5_async_rst", 0, 0, 0, 0);
    pop_chk();
    cyc();
    rst = 1'b0;
    cyc();
    push("t5_after_rst", 0, 0, 0, 0);
    pop_chk();

`ifdef CDT_AUTO_RELOAD_EN
    // periodic reload
    bus.num = 32'd2;
    do_load(0, 2);
    do_start();
    for (int k = 0; k < 3; k++) begin
      run(2);
      push("t6_one", 0, 1, 1, 0);
      pop_chk();
      run(2);
      push("t6_reload", 0, 2, 1, 1);
      pop_chk();
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
